move_link_tx: RTL and testbench

MOVE_LINK_TX -- requirements
Module: move_link_tx

---
 rtl/move_link_tx.sv | 124 ++++++++++++
 tb/tb_move_link_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/move_link_tx.sv
// Move-link serial transmitter: sends every change of move_word as an 8N1 frame through a 4-deep FIFO.
// Define LINK_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module move_link_tx #(
    parameter int CLK_DIV = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] move_word,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);
    localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

`ifdef LINK_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          r_state, w_next;
    logic [7:0]      r_prev;
    logic [7:0]      r_mem [4];
    logic [1:0]      r_wp, r_rp;
    logic [2:0]      r_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit;
    logic [BW-1:0]   r_baud;
    logic            r_tx, r_busy, r_ovf;
    logic            w_push, w_pop, w_full, w_wr, w_tick, w_txl;
`ifdef LINK_PARITY_EN
    logic            r_par;
`endif

    assign w_push = (move_word != r_prev);
    assign w_pop  = (r_state == IDLE) && (r_cnt != 3'd0);
    assign w_full = (r_cnt == 3'd4);
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_tick = (r_baud == BW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= move_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 8'd0;
            r_wp   <= 2'd0;
            r_rp   <= 2'd0;
            r_cnt  <= 3'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_prev <= move_word;
            if (w_wr)  r_wp <= r_wp + 2'd1;
            if (w_pop) r_rp <= r_rp + 2'd1;
            r_cnt <= r_cnt + {2'b0, w_wr} - {2'b0, w_pop};
            if (w_push && !w_wr) r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_txl  = 1'b1;
        case (r_state)
            IDLE:   if (w_pop) w_next = START;
            START: begin
                w_txl = 1'b0;
                if (w_tick) w_next = DATA;
            end
            DATA: begin
                w_txl = r_shift[0];
`ifdef LINK_PARITY_EN
                if (w_tick && r_bit == 3'd7) w_next = PARITY;
`else
                if (w_tick && r_bit == 3'd7) w_next = STOP;
`endif
            end
`ifdef LINK_PARITY_EN
            PARITY: begin
                w_txl = r_par;
                if (w_tick) w_next = STOP;
            end
`endif
            STOP:   if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // tx is registered, so the line lags the state by one cycle; every level still lasts CLK_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
`ifdef LINK_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_tx    <= w_txl;
            r_busy  <= (r_state != IDLE) || (r_cnt != 3'd0);
            if (r_state == IDLE || w_tick) r_baud <= '0;
            else                           r_baud <= r_baud + BW'(1);
            if (w_pop) begin
                r_shift <= r_mem[r_rp];
                r_bit   <= 3'd0;
`ifdef LINK_PARITY_EN
                r_par   <= ^r_mem[r_rp];
`endif
            end else if (r_state == DATA && w_tick) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_move_link_tx.sv
// Scoreboard bench for move_link_tx: a queue-level model predicts frames and start times,
// a line monitor decodes tx and checks each frame plus busy/overflow every cycle.
module tb_move_link_tx;
    localparam int D = 4;
`ifdef LINK_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] move_word = 8'd0;
    logic       tx, busy, overflow;

    move_link_tx #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .move_word(move_word),
        .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] w; int t; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] m_q[$];
    logic [7:0] m_prev = 8'd0;
    int         m_left = 0;
    logic       m_ov = 1'b0, m_busy = 1'b0;
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // reference model: pending words queue (cap 4) and a countdown for the frame on the wire
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_q.delete(); exp_q.delete();
                m_prev = 8'd0; m_left = 0; m_ov = 1'b0; m_busy = 1'b0;
            end else begin
                bit   pop, push;
                exp_t e;
                m_busy = (m_left != 0) || (m_q.size() != 0);
                pop    = (m_left == 0) && (m_q.size() != 0);
                push   = (move_word != m_prev);
                if (pop) begin
                    e.w = m_q.pop_front();
                    e.t = cyc + 1;
                    exp_q.push_back(e);
                    m_left = FRAME;
                end else if (m_left > 0) begin
                    m_left--;
                end
                if (push) begin
                    if (m_q.size() < 4) m_q.push_back(move_word);
                    else m_ov = 1'b1;
                end
                m_prev = move_word;
            end
        end
    end

    // line monitor: decodes frames off tx and scores them against the expected queue
    initial begin
        bit       act;
        int       k, t0;
        logic     s [NB*D];
        logic [NB-1:0] b;
        bit       stable;
        exp_t     e;
        act = 0; k = 0; t0 = 0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("busy", {31'd0, busy}, {31'd0, m_busy});
                chk("overflow", {31'd0, overflow}, {31'd0, m_ov});
            end
            if (rst) act = 0;
            else begin
                if (!act && tx !== 1'b1) begin act = 1; k = 0; t0 = cyc; end
                if (act) begin
                    s[k] = tx;
                    k++;
                    if (k == NB*D) begin
                        act = 0;
                        stable = 1;
                        for (int i = 0; i < NB; i++) begin
                            b[i] = s[i*D];
                            for (int j = 1; j < D; j++)
                                if (s[i*D+j] !== b[i]) stable = 0;
                        end
                        if (exp_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_frame: got data %0h at cycle %0d, expected no frame", b[8:1], t0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_start", t0, e.t);
                            chk("bit_width", {31'd0, stable}, 32'd1);
                            chk("frame_data", {24'd0, b[8:1]}, {24'd0, e.w});
                            chk("start_stop", {30'd0, b[0], b[NB-1]}, 32'd1);
`ifdef LINK_PARITY_EN
                            chk("parity", {31'd0, b[9]}, {31'd0, ^e.w});
`endif
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_left != 0 || m_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("drain_timeout", {31'd0, n >= 3000}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; move_word = 8'd0;
        tick(3);
        rst = 1'b0;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);

        // quiet line while the word never changes
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            chk("quiet_tx", {31'd0, tx}, 32'd1);
        end

        move_word = 8'hA5; drain();
        move_word = 8'h07; drain();
        move_word = 8'hA5; drain();

        // burst of changes while a frame is in flight fills the FIFO and drops the fifth
        move_word = 8'h80;
        tick(10);
        for (int i = 1; i <= 5; i++) begin
            move_word = 8'(i);
            tick(1);
        end
        chk("burst_overflow", {31'd0, overflow}, 32'd1);
        drain();

        // reset during data bit 3 abandons the frame
        move_word = 8'h5A;
        tick(1 + 4*D + 1);
        rst = 1'b1; move_word = 8'h00;
        tick(1);
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_ovf", {31'd0, overflow}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(200);
        chk("post_reset_silent", exp_q.size(), 32'd0);

        // nonzero word across reset is re-announced
        move_word = 8'h3C; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        drain();

        move_word = 8'h10; drain();
        move_word = 8'h20; tick(200); drain();

        for (int i = 0; i < 60; i++) begin
            move_word = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) tick(1);
            else tick($urandom_range(1, 70));
        end
        drain();
        chk("final_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
